// File: rtl/alarm_banner_scan_ctrl.sv
// Scan controller for the 4-digit seven-segment panel. It multiplexes the time readout
// with the blinking "UPUP" alarm banner and returns to the time readout on ack or timeout.
module alarm_banner_scan_ctrl #(
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 64,
  parameter int MAX_BLINKS = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] time_bcd,
  input  logic        alarm_req,
  input  logic        alarm_ack,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        alarm_active,
  output logic        timeout_pulse
);

  localparam int DIV_W = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int FRM_W = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;
  localparam int BLK_W = (MAX_BLINKS > 1) ? $clog2(MAX_BLINKS) : 1;

  localparam logic [6:0] GLYPH_U = 7'b0111110;
  localparam logic [6:0] GLYPH_P = 7'b1100111;

  typedef enum logic [1:0] {
    S_TIME = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_digit;
  logic [FRM_W-1:0] r_frame;
  logic [FRM_W-1:0] w_frame_next;
  logic [BLK_W-1:0] r_blink;
  logic [BLK_W-1:0] w_blink_next;
  logic             r_silenced;
  logic             w_silenced_next;
  logic             r_timeout;
  logic             w_timeout_next;
  logic [6:0]       r_seg;
  logic [6:0]       w_seg_next;
  logic [3:0]       r_an;
  logic [3:0]       w_an_next;
  logic             w_div_tc;
  logic             w_frame_bnd;
  logic             w_half_done;
  logic [3:0]       w_nibble;

  function automatic logic [6:0] decode_bcd(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Scan counters free-run regardless of display state so a mode change never glitches the scan.
  assign w_div_tc    = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_frame_bnd = w_div_tc && (r_digit == 2'd3);
  assign w_half_done = w_frame_bnd && (r_frame == FRM_W'(BLINK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_digit <= 2'd0;
    end else if (w_div_tc) begin
      r_div   <= '0;
      r_digit <= r_digit + 2'd1;
    end else begin
      r_div   <= r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_TIME;
      r_frame    <= '0;
      r_blink    <= '0;
      r_silenced <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_frame    <= w_frame_next;
      r_blink    <= w_blink_next;
      r_silenced <= w_silenced_next;
      r_timeout  <= w_timeout_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_frame_next   = r_frame;
    w_blink_next   = r_blink;
    w_timeout_next = 1'b0;
    case (r_state)
      S_TIME: begin
        // An ack in the same cycle silences the request, so it also blocks entry.
        if (alarm_req && !r_silenced && !alarm_ack) begin
          w_state_next = S_ON;
          w_frame_next = '0;
          w_blink_next = '0;
        end
      end
      S_ON: begin
        if (alarm_ack || !alarm_req) begin
          w_state_next = S_TIME;
        end else if (w_half_done) begin
          w_state_next = S_OFF;
          w_frame_next = '0;
        end else if (w_frame_bnd) begin
          w_frame_next = r_frame + FRM_W'(1);
        end
      end
      S_OFF: begin
        if (alarm_ack || !alarm_req) begin
          w_state_next = S_TIME;
        end else if (w_half_done) begin
          w_frame_next = '0;
          if (r_blink == BLK_W'(MAX_BLINKS - 1)) begin
            w_state_next   = S_TIME;
            w_timeout_next = 1'b1;
          end else begin
            w_state_next = S_ON;
            w_blink_next = r_blink + BLK_W'(1);
          end
        end else if (w_frame_bnd) begin
          w_frame_next = r_frame + FRM_W'(1);
        end
      end
      default: w_state_next = S_TIME;
    endcase

    if (!alarm_req) begin
      w_silenced_next = 1'b0;
    end else if (alarm_ack || w_timeout_next) begin
      w_silenced_next = 1'b1;
    end else begin
      w_silenced_next = r_silenced;
    end
  end

  always_comb begin
    alarm_active = (r_state == S_ON) || (r_state == S_OFF);
    case (r_digit)
      2'd0:    w_nibble = time_bcd[3:0];
      2'd1:    w_nibble = time_bcd[7:4];
      2'd2:    w_nibble = time_bcd[11:8];
      default: w_nibble = time_bcd[15:12];
    endcase
    case (r_state)
      S_ON:    w_seg_next = r_digit[0] ? GLYPH_U : GLYPH_P;
      S_OFF:   w_seg_next = 7'b0000000;
      default: w_seg_next = decode_bcd(w_nibble);
    endcase
    w_an_next = 4'b0001 << r_digit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= 7'b0000000;
      r_an  <= 4'b0000;
    end else begin
      r_seg <= w_seg_next;
      r_an  <= w_an_next;
    end
  end

  assign seg           = r_seg;
  assign an            = r_an;
  assign timeout_pulse = r_timeout;

endmodule

// File: tb/tb_alarm_banner_scan_ctrl.sv
// Randomized bench for alarm_banner_scan_ctrl against a cycle-count reference model
// (scan position from elapsed clocks, banner progress as a phase number).
module tb_alarm_banner_scan_ctrl;

  localparam int SD = 2;
  localparam int BD = 2;
  localparam int MB = 3;

  logic        clk;
  logic        rst_n;
  logic [15:0] time_bcd;
  logic        alarm_req;
  logic        alarm_ack;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        alarm_active;
  logic        timeout_pulse;

  alarm_banner_scan_ctrl #(
    .SCAN_DIV  (SD),
    .BLINK_DIV (BD),
    .MAX_BLINKS(MB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .time_bcd     (time_bcd),
    .alarm_req    (alarm_req),
    .alarm_ack    (alarm_ack),
    .seg          (seg),
    .an           (an),
    .alarm_active (alarm_active),
    .timeout_pulse(timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
                               7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
  // "UPUP" read left to right, indexed by digit number (digit0 is rightmost).
  logic [6:0] banner [4] = '{7'b1100111, 7'b0111110, 7'b1100111, 7'b0111110};

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: clocks since reset, banner on/off, phase number, frames within phase.
  int m_t, m_mode, m_phase, m_frames;
  bit m_sil;
  logic [6:0] e_seg;
  logic [3:0] e_an;
  logic       e_to;
  int to_seen;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_mode = 0; m_phase = 0; m_frames = 0; m_sil = 0;
    e_seg = '0; e_an = '0; e_to = 0;
  endtask

  task automatic model_edge();
    int  d;
    bit  bnd;
    logic [15:0] b;
    d   = (m_t / SD) % 4;
    bnd = (m_t % (4 * SD)) == (4 * SD - 1);
    b   = time_bcd >> (4 * d);
    e_an = 4'b0001 << d;
    if (m_mode == 0)            e_seg = seg_tbl[b[3:0]];
    else if (m_phase % 2 == 0)  e_seg = banner[d];
    else                        e_seg = 7'b0000000;
    e_to = 0;
    if (m_mode == 0) begin
      if (alarm_req && !m_sil && !alarm_ack) begin
        m_mode = 1; m_phase = 0; m_frames = 0;
      end
    end else if (alarm_ack || !alarm_req) begin
      m_mode = 0;
    end else if (bnd) begin
      m_frames++;
      if (m_frames == BD) begin
        m_frames = 0;
        m_phase++;
        if (m_phase == 2 * MB) begin
          m_mode = 0; e_to = 1; m_sil = 1;
        end
      end
    end
    if (!alarm_req)     m_sil = 0;
    else if (alarm_ack) m_sil = 1;
    m_t++;
  endtask

  function automatic bit will_timeout();
    return m_mode == 1 && alarm_req && !alarm_ack && m_phase == 2 * MB - 1 &&
           m_frames == BD - 1 && (m_t % (4 * SD)) == (4 * SD - 1);
  endfunction

  // Called at a negedge with inputs set; leaves simulation at the next negedge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_val("seg", 16'(seg), 16'(e_seg));
    check_val("an", 16'(an), 16'(e_an));
    check_val("alarm_active", 16'(alarm_active), 16'(m_mode));
    check_val("timeout_pulse", 16'(timeout_pulse), 16'(e_to));
    if (timeout_pulse) to_seen++;
    @(negedge clk);
    alarm_ack = 1'b0;
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; alarm_req = 1'b0; alarm_ack = 1'b0; time_bcd = 16'h1234;
    model_reset();
    #1;
    check_val("reset_seg", 16'(seg), 16'h0);
    check_val("reset_an", 16'(an), 16'h0);
    check_val("reset_active", 16'(alarm_active), 16'h0);
    check_val("reset_timeout", 16'(timeout_pulse), 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("time readout 1234");
    repeat (24) cycle();

    $display("banner hold to timeout");
    to_seen = 0;
    alarm_req = 1'b1;
    repeat (200) cycle();
    check_val("timeout_count", 16'(to_seen), 16'd1);
    check_val("no_restart", 16'(alarm_active), 16'd0);

    $display("ack during banner on");
    alarm_req = 1'b0;
    repeat (3) cycle();
    alarm_req = 1'b1;
    repeat (5) cycle();
    check_val("banner_on_before_ack", 16'(alarm_active), 16'd1);
    alarm_ack = 1'b1;
    cycle();
    check_val("ack_exit", 16'(alarm_active), 16'd0);
    repeat (20) cycle();

    $display("ack on final boundary");
    alarm_req = 1'b0;
    repeat (2) cycle();
    alarm_req = 1'b1;
    to_seen = 0;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (will_timeout()) begin
        found = 1;
        alarm_ack = 1'b1;
      end
      cycle();
    end
    if (!found) begin
      n_cmp++; n_err++;
      $display("FAIL final_boundary_wait got=timeout want=boundary");
    end
    repeat (4) cycle();
    check_val("ack_wins_no_pulse", 16'(to_seen), 16'd0);

    $display("async reset mid banner off");
    alarm_req = 1'b0;
    repeat (2) cycle();
    alarm_req = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle();
      if (m_mode == 1 && m_phase % 2 == 1 && m_frames == 1) found = 1;
    end
    if (!found) begin
      n_cmp++; n_err++;
      $display("FAIL banner_off_wait got=timeout want=banner_off");
    end
    rst_n = 1'b0;
    #1;
    check_val("arst_seg", 16'(seg), 16'h0);
    check_val("arst_an", 16'(an), 16'h0);
    check_val("arst_active", 16'(alarm_active), 16'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) cycle();

    $display("time readout FA90");
    alarm_req = 1'b0;
    time_bcd = 16'hFA90;
    repeat (20) cycle();

    $display("randomized run");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63) == 0)  time_bcd = 16'($urandom);
      if ($urandom_range(149) == 0) alarm_req = ~alarm_req;
      if ($urandom_range(49) == 0)  alarm_ack = 1'b1;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
